// File: rtl/wb_scoreboard_writer.sv
// Register-file write-port owner: merges ALU results with buffered load
// responses onto one registered write port. It also keeps a per-register
// scoreboard of outstanding loads and raises a decode stall on RAW/WAW hazards
// or when the load queue is exhausted.
module wb_scoreboard_writer #(
    parameter int XLEN     = 32,
    parameter int NREG     = 32,
    parameter int LQ_DEPTH = 4,
    localparam int RW      = $clog2(NREG)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   issue_valid,
    input  logic                   issue_is_load,
    input  logic [RW-1:0]          issue_rd,
    input  logic [RW-1:0]          issue_rs1,
    input  logic [RW-1:0]          issue_rs2,
    input  logic                   issue_use_rs1,
    input  logic                   issue_use_rs2,
    output logic                   stall,
    input  logic                   alu_valid,
    input  logic [RW-1:0]          alu_rd,
    input  logic signed [XLEN-1:0] alu_data,
    input  logic                   ld_valid,
    input  logic [RW-1:0]          ld_rd,
    input  logic signed [XLEN-1:0] ld_data,
    output logic                   ld_ready,
    output logic                   regWrite,
    output logic [RW-1:0]          rd,
    output logic signed [XLEN-1:0] write_Data,
    output logic [NREG-1:0]        pending,
    output logic                   wb_err
);

    localparam int PW = (LQ_DEPTH > 1) ? $clog2(LQ_DEPTH) : 1;
    localparam int CW = $clog2(LQ_DEPTH + 1);
    localparam logic [CW-1:0] DEPTH_C  = CW'(LQ_DEPTH);
    localparam logic [PW-1:0] LAST_PTR = PW'(LQ_DEPTH - 1);

    // Load-response queue storage (data only, no reset needed)
    logic [RW-1:0]          lq_rd   [LQ_DEPTH];
    logic signed [XLEN-1:0] lq_data [LQ_DEPTH];
    logic [PW-1:0]          wr_ptr, rd_ptr;
    logic [CW-1:0]          lq_count;
    logic [CW-1:0]          outstanding;

    logic                   raw, waw, lqf, accept, ld_issue;
    logic                   push, pop, alu_win, ld_done;
    logic [RW-1:0]          head_rd;
    logic signed [XLEN-1:0] head_data;
    logic [NREG-1:0]        pending_nxt;

    // Hazard detection, handshake and write-port arbitration decisions
    always_comb begin
        raw       = (issue_use_rs1 && pending[issue_rs1]) ||
                    (issue_use_rs2 && pending[issue_rs2]);
        waw       = (issue_rd != '0) && pending[issue_rd];
        lqf       = issue_is_load && (outstanding == DEPTH_C);
        stall     = issue_valid && (raw || waw || lqf);
        accept    = issue_valid && !stall;
        ld_issue  = accept && issue_is_load;
        ld_ready  = (lq_count != DEPTH_C);
        push      = ld_valid && ld_ready;
        // An ALU write to x0 is a no-op and must not steal the port from the queue
        alu_win   = alu_valid && (alu_rd != '0);
        pop       = !alu_win && (lq_count != '0);
        ld_done   = pop && (outstanding != '0);
        head_rd   = lq_rd[rd_ptr];
        head_data = lq_data[rd_ptr];
    end

    // Scoreboard update: clear on writeback, then set on issue so a same-cycle set wins
    always_comb begin
        pending_nxt = pending;
        if (pop) pending_nxt[head_rd] = 1'b0;
        if (ld_issue && (issue_rd != '0)) pending_nxt[issue_rd] = 1'b1;
        pending_nxt[0] = 1'b0;
    end

    // Queue storage write on an accepted load response
    always_ff @(posedge clk) begin
        if (push) begin
            lq_rd[wr_ptr]   <= ld_rd;
            lq_data[wr_ptr] <= ld_data;
        end
    end

    // Queue pointers, occupancy and outstanding-load bookkeeping
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            lq_count    <= '0;
            outstanding <= '0;
        end else begin
            if (push) wr_ptr <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + 1'b1;
            if (pop)  rd_ptr <= (rd_ptr == LAST_PTR) ? '0 : rd_ptr + 1'b1;
            unique case ({push, pop})
                2'b10:   lq_count <= lq_count + 1'b1;
                2'b01:   lq_count <= lq_count - 1'b1;
                default: lq_count <= lq_count;
            endcase
            unique case ({ld_issue, ld_done})
                2'b10:   outstanding <= outstanding + 1'b1;
                2'b01:   outstanding <= outstanding - 1'b1;
                default: outstanding <= outstanding;
            endcase
        end
    end

    // Registered write port, scoreboard and sticky error flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            regWrite   <= 1'b0;
            rd         <= '0;
            write_Data <= '0;
            pending    <= '0;
            wb_err     <= 1'b0;
        end else begin
            pending <= pending_nxt;
            if (alu_win) begin
                regWrite   <= 1'b1;
                rd         <= alu_rd;
                write_Data <= alu_data;
                if (pending[alu_rd]) wb_err <= 1'b1;
            end else if (pop) begin
                // Loads to x0 are drained silently: the index/data move but no write
                regWrite   <= (head_rd != '0);
                rd         <= head_rd;
                write_Data <= head_data;
            end else begin
                regWrite   <= 1'b0;
            end
        end
    end

endmodule
